imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension unit for the MiniMIPS datapath. It replaces the
//  fixed combinational 6->32 extenders. Each input is converted by one of four modes: zero-extend,
//  sign-extend, sign-extend then shift left (branch offsets), or upper-load placement.
//  It sits between decode and the ALU operand mux, with valid/ready handshakes on both sides.
// PARAMETERS
//  IN_W   6   width of the incoming immediate field, 1..OUT_W
//  OUT_W  32  width of the extended result
//  SHIFT  2   left-shift amount applied in MODE_SHL, 0..OUT_W-1
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  in_valid    in   1      upstream holds a valid immediate
//  in_ready    out  1      unit can accept; a transfer happens when in_valid & in_ready
//  in_value    in   IN_W   raw immediate field
//  in_mode     in   2      extension mode, encodings from imm_ext_pkg
//  out_valid   out  1      out_result/out_ovf are valid
//  out_ready   in   1      downstream accepts; a transfer happens when out_valid & out_ready
//  out_result  out  OUT_W  extended immediate
//  out_ovf     out  1      MODE_SHL only: the shifted value does not fit in OUT_W (signed)
// BEHAVIOUR
//  - Reset is synchronous. While reset=1 at a clock edge, the next state is:
//    out_valid=0, out_result=0, out_ovf=0, skid empty.
//    in_ready=0 while reset is high; in_ready=1 from the first cycle after reset falls.
//  - Modes:
//    MODE_ZX=2'b00: {zeros, in_value}.
//    MODE_SX=2'b01: {OUT_W-IN_W copies of in_value[IN_W-1], in_value}.
//    MODE_SHL=2'b10: (SX result) << SHIFT, truncated to OUT_W.
//    MODE_LUI=2'b11: in_value placed at [OUT_W-1 -: IN_W], lower bits zero.
//  - out_ovf is 1 only in MODE_SHL when the dropped bits and the result MSB are not all equal.
//    It is 0 in every other mode.
//  - If IN_W == OUT_W, ZX and SX both pass in_value through unchanged.
//    If IN_W > OUT_W, or SHIFT >= OUT_W, elaboration fails via a generate-time $error.
//  - Latency is 1 cycle. A transfer accepted at edge N is visible on out_* after edge N.
//    Throughput is one per cycle while out_ready=1.
//  - Storage is a 2-entry buffer: output register plus one skid register.
//    in_ready = !skid_full, and it is driven from a register (no comb path from out_ready).
//  - Stall: if out_valid & !out_ready, the output register holds its value and the next accepted
//    item goes to the skid register, after which in_ready drops to 0.
//  - When out_ready rises, the skid entry moves to the output register on that edge.
//    in_ready returns to 1 on the next cycle.
//  - Simultaneous output drain and input accept with the skid empty: the new item loads directly
//    into the output register, so there is no bubble.
//  - Ordering is strictly FIFO. No item is dropped or duplicated under any out_ready pattern.
//  - Reset mid-operation discards both entries. No stale out_valid is seen after reset.
//  - out_* are stable while out_valid & !out_ready (AXI-style hold rule). Upstream obeys the same
//    rule on in_*.
// STRUCTURE
//  - imm_ext_pkg: MODE_ZX/MODE_SX/MODE_SHL/MODE_LUI localparams and the imm_mode_t 2-bit typedef.
//  - The extension/shift/ovf datapath is a combinational function inside the top module.
//  - One sub-module: pipe_skid_reg #(W) holds the 2-entry valid/ready buffer.
//    W = OUT_W+1, carrying {ovf, result}. It is reusable elsewhere in the pipeline.
// TESTING (IN_W=6, OUT_W=32, SHIFT=2 unless stated)
//  1. in_value=6'b100101, MODE_SX -> 32'hFFFFFFE5; MODE_ZX -> 32'h00000025.
//     Each appears one cycle after accept, ovf=0.
//  2. MODE_SHL, 6'b111111 -> 32'hFFFFFFFC, ovf=0.
//     MODE_LUI, 6'h25 -> 32'h94000000.
//  3. Config IN_W=8, OUT_W=8, SHIFT=2: MODE_SHL 8'h7F -> 8'hFC, out_ovf=1.
//     8'hF0 -> 8'hC0, out_ovf=0.
//  4. Backpressure: out_ready=0, push A=6'h01 and B=6'h02 (SX) on back-to-back cycles.
//     in_ready falls after B and out_result stays 32'h1.
//     Raise out_ready: A then B on consecutive cycles, in_ready back to 1.
//  5. Streaming: 16 random items with in_valid=1 and random out_ready.
//     A scoreboard shows exact order, no loss or duplication, and 1/cycle when out_ready stays 1.
//  6. Assert reset with both entries full.
//     Next cycle: out_valid=0, out_result=0, in_ready=0.
//     After release: in_ready=1, and the first new item emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate-extension unit.
package imm_ext_pkg;

  typedef logic [1:0] imm_mode_t;

  localparam imm_mode_t MODE_ZX  = 2'b00;
  localparam imm_mode_t MODE_SX  = 2'b01;
  localparam imm_mode_t MODE_SHL = 2'b10;
  localparam imm_mode_t MODE_LUI = 2'b11;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline buffer: an output register plus one skid register.
// The upstream ready is registered, so there is no combinational path from out_ready_i.
module pipe_skid_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_q, ready_d;
  logic         accept, out_free;

  always_comb begin
    accept       = in_valid_i & ready_q;
    out_free     = ~out_valid_q | out_ready_i;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      // ready_q is low whenever the skid is occupied, so skid refill and accept never collide
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign extend, sign extend + shift, or upper placement,
// followed by a 2-entry valid/ready buffer carrying {ovf, result}.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_value,
  input  imm_mode_t        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic             out_ovf
);

  localparam int unsigned WideW = OUT_W + SHIFT;

  if (IN_W == 0 || IN_W > OUT_W || SHIFT >= OUT_W) begin : g_param_check
    $error("imm_extend_pipe: need 1 <= IN_W <= OUT_W and SHIFT < OUT_W");
  end

  // Returns {ovf, result}.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] v, input imm_mode_t m);
    logic [WideW-1:0] wide;
    logic [OUT_W-1:0] res;
    logic             ovf;
    wide = WideW'($signed(v)) << SHIFT;
    res  = '0;
    ovf  = 1'b0;
    unique case (m)
      MODE_ZX:  res = OUT_W'(v);
      MODE_SX:  res = OUT_W'($signed(v));
      MODE_SHL: begin
        res = wide[OUT_W-1:0];
        // Dropped bits plus the new MSB must all match for the value to survive
        ovf = (|wide[WideW-1:OUT_W-1]) & ~(&wide[WideW-1:OUT_W-1]);
      end
      MODE_LUI: res = OUT_W'(v) << (OUT_W - IN_W);
      default:  res = '0;
    endcase
    return {ovf, res};
  endfunction

  logic [OUT_W:0] ext_data;
  logic [OUT_W:0] buf_data;

  assign ext_data = extend(in_value, in_mode);

  pipe_skid_reg #(
    .W(OUT_W + 1)
  ) u_skid (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (ext_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (buf_data)
  );

  assign {out_ovf, out_result} = buf_data;

endmodule
